// File: rtl/addrc_lane_engine.sv
// Add-round-constant engine: walks lanes of an external single-port state RAM,
// XORing each processed lane with a round constant latched at start.
// Modes: a single fixed target lane, or every lane 0..NUM_LANES-1 in order.
// Every output is a flop loaded from the next-state decode. Each output
// therefore changes in the same cycle as the state it belongs to.
module addrc_lane_engine #(
  parameter int unsigned LANE_W      = 64,
  parameter int unsigned NUM_LANES   = 25,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned TARGET_LANE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode_all,
  input  logic [LANE_W-1:0] rc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [LANE_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [LANE_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LANES - 1);
  localparam logic [ADDR_W-1:0] TGT_IDX  = ADDR_W'(TARGET_LANE);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_XOR  = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [LANE_W-1:0]   rc_q, rc_d;
  logic                mode_q, mode_d;

  logic [ADDR_W-1:0]   addr_d;
  logic                rd_d;
  logic                wr_d;
  logic [LANE_W-1:0]   wdata_d;
  logic                busy_d;
  logic                done_d;

  // Next-state, lane index and latches, then outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rc_d    = rc_q;
    mode_d  = mode_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rc_d    = rc;
          mode_d  = mode_all;
          idx_d   = mode_all ? '0 : TGT_IDX;
          state_d = S_RD;
        end
      end
      S_RD:  state_d = S_XOR;
      S_XOR: state_d = S_WR;
      S_WR: begin
        if (!mode_q || (idx_q == LAST_IDX)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd_d    = (state_d == S_RD);
    wr_d    = (state_d == S_WR);
    addr_d  = (rd_d || wr_d) ? idx_d : '0;
    // Read data is valid during XOR; capture the XORed lane for the WR cycle
    wdata_d = (state_d == S_WR) ? (mem_rdata ^ rc_q) : '0;
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, latches and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      rc_q      <= '0;
      mode_q    <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rc_q      <= rc_d;
      mode_q    <= mode_d;
      mem_addr  <= addr_d;
      mem_rd    <= rd_d;
      mem_wr    <= wr_d;
      mem_wdata <= wdata_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule

// File: tb/tb_addrc_lane_engine.sv
// Testbench for addrc_lane_engine: RAM model plus a lane-level reference model.
module tb_addrc_lane_engine;

  localparam int unsigned LANE_W      = 64;
  localparam int unsigned NUM_LANES   = 25;
  localparam int unsigned ADDR_W      = 5;
  localparam int unsigned TARGET_LANE = 0;

  logic              clk;
  logic              rst;
  logic              start;
  logic              mode_all;
  logic [LANE_W-1:0] rc;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [LANE_W-1:0] mem_rdata;
  logic              mem_wr;
  logic [LANE_W-1:0] mem_wdata;
  logic              busy;
  logic              done;

  int errors = 0;
  int checks = 0;

  logic [LANE_W-1:0] ram [NUM_LANES];
  logic [ADDR_W-1:0] wr_q[$];
  int overlap  = 0;
  int bad_addr = 0;
  int done_cnt = 0;

  addrc_lane_engine #(
    .LANE_W(LANE_W), .NUM_LANES(NUM_LANES), .ADDR_W(ADDR_W), .TARGET_LANE(TARGET_LANE)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode_all(mode_all), .rc(rc),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: one-cycle read latency, write on the clock edge
  always @(posedge clk) begin
    if (mem_wr && (int'(mem_addr) < int'(NUM_LANES))) ram[mem_addr] <= mem_wdata;
    if (mem_rd && (int'(mem_addr) < int'(NUM_LANES))) mem_rdata <= ram[mem_addr];
  end

  // Bus monitor: write order, address legality, strobe exclusivity, done pulses
  always @(negedge clk) begin
    if (mem_wr) wr_q.push_back(mem_addr);
    if (mem_rd || mem_wr) begin
      if (int'(mem_addr) >= int'(NUM_LANES)) bad_addr++;
    end else if (mem_addr != '0) begin
      bad_addr++;
    end
    assert (!(mem_rd && mem_wr)) else overlap++;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind 0: random lanes, kind 1: lane i holds i
  task automatic load_ram(input int kind);
    @(negedge clk);
    for (int i = 0; i < int'(NUM_LANES); i++)
      ram[i] <= (kind == 1) ? 64'(i) : {$urandom, $urandom};
    @(negedge clk);
  endtask

  task automatic clear_mon();
    wr_q.delete();
    overlap  = 0;
    bad_addr = 0;
    done_cnt = 0;
  endtask

  // One full operation checked against the lane-level model
  task automatic run_op(input logic mode, input logic [63:0] rcv, input bit perturb, input string tag);
    logic [63:0] exp [NUM_LANES];
    int tq[$];
    int lanes, done_k, busy_bad, ram_bad, ord_bad;
    for (int i = 0; i < int'(NUM_LANES); i++) exp[i] = ram[i];
    if (mode) for (int i = 0; i < int'(NUM_LANES); i++) tq.push_back(i);
    else tq.push_back(int'(TARGET_LANE));
    foreach (tq[j]) exp[tq[j]] = exp[tq[j]] ^ rcv;
    lanes = tq.size();

    @(negedge clk);
    clear_mon();
    start = 1'b1; mode_all = mode; rc = rcv;
    done_k = -1; busy_bad = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      start = perturb ? 1'($urandom_range(0, 1)) : 1'b0;
      if (perturb) begin
        rc = {$urandom, $urandom};
        mode_all = 1'($urandom_range(0, 1));
      end
      if (busy !== 1'b1) busy_bad++;
      if (done === 1'b1) begin
        done_k = k;
        break;
      end
    end
    check({tag, " done_cycle"}, 64'(done_k), 64'(3 * lanes + 1));
    check({tag, " busy_while_active"}, 64'(busy_bad), 64'd0);

    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after"}, 64'(busy), 64'd0);
    check({tag, " done_count"}, 64'(done_cnt), 64'd1);
    check({tag, " write_count"}, 64'(wr_q.size()), 64'(lanes));
    ord_bad = 0;
    foreach (tq[j]) if (j >= wr_q.size() || int'(wr_q[j]) != tq[j]) ord_bad++;
    check({tag, " write_order"}, 64'(ord_bad), 64'd0);
    ram_bad = 0;
    for (int i = 0; i < int'(NUM_LANES); i++) if (ram[i] !== exp[i]) ram_bad++;
    check({tag, " ram_contents"}, 64'(ram_bad), 64'd0);
    check({tag, " rd_wr_overlap"}, 64'(overlap), 64'd0);
    check({tag, " bad_addr"}, 64'(bad_addr), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r, l0, l1, t3_exp;
    int other_bad;
    logic [63:0] snap [NUM_LANES];

    rst = 1'b1; start = 1'b0; mode_all = 1'b0; rc = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset mem_rd", 64'(mem_rd), 64'd0);
    check("reset mem_wr", 64'(mem_wr), 64'd0);
    check("reset mem_addr", 64'(mem_addr), 64'd0);
    check("reset mem_wdata", mem_wdata, 64'd0);
    rst = 1'b0;

    // T1: single target lane
    load_ram(0);
    @(negedge clk); ram[0] <= 64'h0; @(negedge clk);
    run_op(1'b0, 64'h8000_0000_0000_808B, 1'b0, "t1");
    check("t1 lane0", ram[0], 64'h8000_0000_0000_808B);

    // T2: all lanes, lane i = i, all-ones constant
    load_ram(1);
    run_op(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "t2");
    check("t2 lane7", ram[7], ~64'd7);
    check("t2 lane24", ram[24], ~64'd24);

    // T6: zero constant leaves contents unchanged
    load_ram(0);
    run_op(1'b1, 64'h0, 1'b0, "t6");

    // T5: inputs churn while busy
    for (int n = 0; n < 4; n++) begin
      load_ram(0);
      run_op(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b1, "t5");
    end

    // Random operations
    for (int n = 0; n < 6; n++) begin
      load_ram(0);
      run_op(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b0, "rand");
    end

    // T3: start held high, single-lane mode -> accept every 5 cycles
    load_ram(0);
    r = {$urandom, $urandom};
    for (int i = 0; i < int'(NUM_LANES); i++) snap[i] = ram[i];
    t3_exp = snap[TARGET_LANE] ^ r;
    @(negedge clk);
    clear_mon();
    start = 1'b1; mode_all = 1'b0; rc = r;
    repeat (25) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("t3 done_count", 64'(done_cnt), 64'd5);
    check("t3 write_count", 64'(wr_q.size()), 64'd5);
    check("t3 target_lane", ram[TARGET_LANE], t3_exp);
    other_bad = 0;
    for (int i = 0; i < int'(NUM_LANES); i++)
      if (i != int'(TARGET_LANE) && ram[i] !== snap[i]) other_bad++;
    check("t3 other_lanes", 64'(other_bad), 64'd0);
    check("t3 overlap", 64'(overlap), 64'd0);

    // T4: reset during the second lane's XOR cycle
    load_ram(0);
    r = {$urandom, $urandom};
    l0 = ram[0]; l1 = ram[1];
    @(negedge clk);
    clear_mon();
    start = 1'b1; mode_all = 1'b1; rc = r;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t4 busy", 64'(busy), 64'd0);
    check("t4 done", 64'(done), 64'd0);
    check("t4 mem_rd", 64'(mem_rd), 64'd0);
    check("t4 mem_wr", 64'(mem_wr), 64'd0);
    check("t4 mem_addr", 64'(mem_addr), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t4 lane0", ram[0], l0 ^ r);
    check("t4 lane1", ram[1], l1);
    check("t4 done_count", 64'(done_cnt), 64'd0);
    check("t4 write_count", 64'(wr_q.size()), 64'd1);

    // Engine still usable after the aborted run
    run_op(1'b1, {$urandom, $urandom}, 1'b0, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
